// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-lite pipeline.
package mips_pkg;

    localparam int DATA         = 32;
    localparam int ADDRESSWIDTH = 32;

    // Default PC loaded by reset in the fetch stage.
    localparam logic [ADDRESSWIDTH-1:0] RESET_PC = 32'h0000_0000;

    typedef logic [DATA-1:0] Instruct;

    // Fetch-stage control states.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        HALT  = 2'b10
    } FetchState;

endpackage

// File: rtl/adder.sv
// Generic ripple adder with carry-in; overflow is the carry out of the MSB.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH:0] full_s;

    // Widen by one bit so the carry out lands in the MSB.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

    assign sum      = full_s[WIDTH-1:0];
    assign overflow = full_s[WIDTH];

endmodule

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush clears the valid bit, load captures a new
// entry, otherwise the current entry is held for decode.
module ifid_reg
#(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATA         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    flush,
    input  logic [DATA-1:0]         next_instr,
    input  logic [ADDRESSWIDTH-1:0] next_pc4,
    output logic [DATA-1:0]         instruction,
    output logic [ADDRESSWIDTH-1:0] pcPlus4,
    output logic                    fetchValid
);

    logic [DATA-1:0]         instr_r;
    logic [ADDRESSWIDTH-1:0] pc4_r;
    logic                    valid_r;

    // Pipeline register update: flush wins over load, load wins over hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_r <= {DATA{1'b0}};
            pc4_r   <= {ADDRESSWIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            instr_r <= next_instr;
            pc4_r   <= next_pc4;
            valid_r <= 1'b1;
        end else begin
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end
    end

    assign instruction = instr_r;
    assign pcPlus4     = pc4_r;
    assign fetchValid  = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ready/valid instruction
// memory port, fills IF/ID and services redirect, stall and halt.
module fetch_stage
#(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATA         = 32,
    parameter logic [ADDRESSWIDTH-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branchTaken,
    input  logic [DATA-1:0]         newAddress,
    input  logic                    stall,
    input  logic                    haltDetected,
    output logic                    imemReq,
    output logic [ADDRESSWIDTH-1:0] imemAddr,
    input  logic                    imemReady,
    input  logic [DATA-1:0]         imemRdata,
    output mips_pkg::Instruct       instruction,
    output logic [ADDRESSWIDTH-1:0] pcPlus4,
    output logic                    fetchValid
);

    import mips_pkg::*;

    localparam logic [ADDRESSWIDTH-1:0] PC_STEP = {{(ADDRESSWIDTH-3){1'b0}}, 3'd4};
    localparam logic [DATA-1:0] WORD_MASK = {{(DATA-2){1'b1}}, 2'b00};

    FetchState               state_r, state_nxt_s;
    logic [ADDRESSWIDTH-1:0] pc_r, pc_nxt_s;
    logic [DATA-1:0]         skid_r, skid_nxt_s;
    logic [ADDRESSWIDTH-1:0] redirect_pc_r, redirect_pc_nxt_s;
    logic                    redirect_pend_r, redirect_pend_nxt_s;
    logic                    halt_pend_r, halt_pend_nxt_s;
    logic [ADDRESSWIDTH-1:0] pc_plus4_s;
    logic                    pc_carry_unused_s;
    logic [DATA-1:0]         target_full_s;
    logic [ADDRESSWIDTH-1:0] target_s;
    logic                    ifid_load_s, ifid_flush_s;
    logic [DATA-1:0]         ifid_instr_s;
    logic [ADDRESSWIDTH-1:0] ifid_pc4_s;

    adder #(.WIDTH(ADDRESSWIDTH)) u_pc_adder (
        .a        (pc_r),
        .b        (PC_STEP),
        .cin      (1'b0),
        .sum      (pc_plus4_s),
        .overflow (pc_carry_unused_s)
    );

    // Redirect targets are always word aligned.
    always_comb begin
        target_full_s = newAddress & WORD_MASK;
        target_s      = target_full_s[ADDRESSWIDTH-1:0];
    end

    // Memory request is decoded from state; the address is the PC, which only
    // moves on a completed response or outside FETCH, so it stays stable.
    assign imemReq  = rst_n & (state_r == FETCH);
    assign imemAddr = pc_r;

    // Next-state and IF/ID control; branch beats halt, halt beats normal flow.
    always_comb begin
        state_nxt_s         = state_r;
        pc_nxt_s            = pc_r;
        skid_nxt_s          = skid_r;
        redirect_pc_nxt_s   = redirect_pc_r;
        redirect_pend_nxt_s = redirect_pend_r;
        halt_pend_nxt_s     = halt_pend_r;
        ifid_load_s         = 1'b0;
        ifid_flush_s        = 1'b0;
        ifid_instr_s        = imemRdata;
        ifid_pc4_s          = pc_plus4_s;
        case (state_r)
            FETCH: begin
                if (branchTaken) begin
                    ifid_flush_s    = 1'b1;
                    halt_pend_nxt_s = 1'b0;
                    if (imemReady) begin
                        pc_nxt_s            = target_s;
                        redirect_pend_nxt_s = 1'b0;
                    end else begin
                        redirect_pc_nxt_s   = target_s;
                        redirect_pend_nxt_s = 1'b1;
                    end
                end else if (haltDetected || halt_pend_r) begin
                    // The word in flight is never used; park once it lands.
                    ifid_flush_s = !stall;
                    if (imemReady) begin
                        state_nxt_s         = HALT;
                        halt_pend_nxt_s     = 1'b0;
                        redirect_pend_nxt_s = 1'b0;
                    end else begin
                        halt_pend_nxt_s = 1'b1;
                    end
                end else if (imemReady) begin
                    if (redirect_pend_r) begin
                        pc_nxt_s            = redirect_pc_r;
                        redirect_pend_nxt_s = 1'b0;
                        ifid_flush_s        = !stall;
                    end else if (stall) begin
                        skid_nxt_s  = imemRdata;
                        pc_nxt_s    = pc_plus4_s;
                        state_nxt_s = HOLD;
                    end else begin
                        ifid_load_s = 1'b1;
                        pc_nxt_s    = pc_plus4_s;
                    end
                end else begin
                    ifid_flush_s = !stall;
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    ifid_flush_s = 1'b1;
                    pc_nxt_s     = target_s;
                    state_nxt_s  = FETCH;
                end else if (haltDetected) begin
                    ifid_flush_s = !stall;
                    state_nxt_s  = HALT;
                end else if (!stall) begin
                    ifid_load_s  = 1'b1;
                    ifid_instr_s = skid_r;
                    ifid_pc4_s   = pc_r;
                    state_nxt_s  = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            HALT: begin
                ifid_flush_s = branchTaken | !stall;
            end
            default: begin
                state_nxt_s = FETCH;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= FETCH;
            pc_r            <= RESET_PC;
            skid_r          <= {DATA{1'b0}};
            redirect_pc_r   <= {ADDRESSWIDTH{1'b0}};
            redirect_pend_r <= 1'b0;
            halt_pend_r     <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            pc_r            <= pc_nxt_s;
            skid_r          <= skid_nxt_s;
            redirect_pc_r   <= redirect_pc_nxt_s;
            redirect_pend_r <= redirect_pend_nxt_s;
            halt_pend_r     <= halt_pend_nxt_s;
        end
    end

    ifid_reg #(.ADDRESSWIDTH(ADDRESSWIDTH), .DATA(DATA)) u_ifid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifid_load_s),
        .flush       (ifid_flush_s),
        .next_instr  (ifid_instr_s),
        .next_pc4    (ifid_pc4_s),
        .instruction (instruction),
        .pcPlus4     (pcPlus4),
        .fetchValid  (fetchValid)
    );

endmodule
